// File: rtl/branch_predictor.sv
// branch_predictor
//    Fetch-stage dynamic branch predictor. The table is a direct-mapped BTB
//    with a 2-bit saturating direction counter in each entry. Lookup is
//    purely combinational. The update port is written by the execute stage
//    once a branch or jump has resolved.
//
// Ports
//    clk, rst            single clock; synchronous active-high reset
//    PCF_i               fetch PC to look up
//    PredictTakenF_o     predicted taken for PCF_i
//    PredictTargetF_o    predicted next PC (BTB target or PCF_i+4)
//    UpdateEnE_i         resolved branch/jump present in execute
//    PCE_i               PC of the resolved instruction
//    ActualTakenE_i      resolved direction
//    JumpE_i, JalrE_i    resolved instruction is JAL/JALR, or JALR only
//    TakenTargetE_i      resolved taken target
//    MispredictE_i       execute flush request, used for statistics only
//    BranchCount_o       accepted-update count
//    MispredictCount_o   mispredicted-update count
//
// Configuration
//    BP_STATS_EN  when defined, builds the two statistics counters.
//                 Otherwise both count outputs are tied to zero.
//                 Prediction behaviour is the same in both builds.

module branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PCF_i,
   output logic                  PredictTakenF_o,
   output logic [DATA_WIDTH-1:0] PredictTargetF_o,
   input  logic                  UpdateEnE_i,
   input  logic [DATA_WIDTH-1:0] PCE_i,
   input  logic                  ActualTakenE_i,
   input  logic                  JumpE_i,
   input  logic                  JalrE_i,
   input  logic [DATA_WIDTH-1:0] TakenTargetE_i,
   input  logic                  MispredictE_i,
   output logic [31:0]           BranchCount_o,
   output logic [31:0]           MispredictCount_o
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

   logic [ENTRIES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [TAG_W-1:0]      tag_d    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_q [ENTRIES];
   logic [DATA_WIDTH-1:0] target_d [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];
   logic [1:0]            ctr_d    [ENTRIES];

   logic [INDEX_BITS-1:0] idx_f, idx_e;
   logic [TAG_W-1:0]      tag_f, tag_e;
   logic                  hit_f, hit_e;
   logic                  upd_accept;

   // The low PC bits of the resolved PC never reach the table.
   logic [1:0] pce_lsb_unused;
   assign pce_lsb_unused = PCE_i[1:0];

   // ---------------------------------------------------------------- lookup
   assign idx_f = PCF_i[INDEX_BITS+1:2];
   assign tag_f = PCF_i[DATA_WIDTH-1:INDEX_BITS+2];
   assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

   // Masked by rst so the reset cycle itself never predicts taken.
   assign PredictTakenF_o  = hit_f && ctr_q[idx_f][1] && !rst;
   assign PredictTargetF_o = PredictTakenF_o ? target_q[idx_f]
                                             : PCF_i + DATA_WIDTH'(4);

   // ---------------------------------------------------------------- update
   assign idx_e      = PCE_i[INDEX_BITS+1:2];
   assign tag_e      = PCE_i[DATA_WIDTH-1:INDEX_BITS+2];
   assign hit_e      = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign upd_accept = UpdateEnE_i && !rst;

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd_accept) begin
         if (JalrE_i) begin
            // Register-indirect targets are not worth caching; drop any
            // stale entry so it cannot redirect fetch.
            if (hit_e) begin
               valid_d[idx_e] = 1'b0;
            end
         end else if (hit_e) begin
            if (JumpE_i) begin
               ctr_d[idx_e]    = 2'b11;
               target_d[idx_e] = TakenTargetE_i;
            end else if (ActualTakenE_i) begin
               ctr_d[idx_e]    = (ctr_q[idx_e] == 2'b11) ? 2'b11
                                                         : ctr_q[idx_e] + 2'b01;
               target_d[idx_e] = TakenTargetE_i;
            end else begin
               ctr_d[idx_e]    = (ctr_q[idx_e] == 2'b00) ? 2'b00
                                                         : ctr_q[idx_e] - 2'b01;
            end
         end else if (ActualTakenE_i) begin
            // Allocate on taken only; a conflicting entry is simply evicted.
            valid_d[idx_e]  = 1'b1;
            tag_d[idx_e]    = tag_e;
            target_d[idx_e] = TakenTargetE_i;
            ctr_d[idx_e]    = JumpE_i ? 2'b11 : 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
      end
   end

   // Tag and target need no reset: they are only observed behind valid.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   // ------------------------------------------------------------ statistics
`ifdef BP_STATS_EN
   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] mispredict_count_q, mispredict_count_d;

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (upd_accept) begin
         branch_count_d = branch_count_q + 32'd1;
         if (MispredictE_i) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign BranchCount_o     = branch_count_q;
   assign MispredictCount_o = mispredict_count_q;
`else
   logic mispredict_unused;
   assign mispredict_unused = MispredictE_i;
   assign BranchCount_o     = '0;
   assign MispredictCount_o = '0;
`endif

endmodule
